// File: rtl/lsu_bus_master_if.sv
// Word-addressed, byte-strobed request/grant/rvalid data bus between LSU and memory.
interface lsu_bus_master_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, wstrb, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wstrb, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/lsu_bus_master.sv
// Load/store bus initiator: alignment check, lane steering, load extension.
// Optional LSU_TIMEOUT_EN aborts REQ/WAIT_R after TIMEOUT_CYCLES cycles.
module lsu_bus_master
`ifdef LSU_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = 16
)
`endif
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ls_valid,
    input  logic                    ls_we,
    input  logic [2:0]              ls_func3,
    input  logic [31:0]             ls_addr,
    input  logic [31:0]             ls_wdata,
    output logic                    ls_busy,
    output logic                    ls_done,
    output logic                    ls_err,
    output logic [31:0]             ls_rdata,
    lsu_bus_master_if.master        bus
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

    state_t      state, state_d;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic        reject;
    logic        tmo;
    logic        tmo_hit;
    logic [3:0]  strb;
    logic [31:0] sh;
    logic [31:0] ext;

    always_comb begin
        reject = 1'b1;
        unique case (1'b1)
            ls_func3 == 3'b000:
                reject = 1'b0;
            ls_func3 == 3'b001:
                reject = ls_addr[0];
            ls_func3 == 3'b010:
                reject = |ls_addr[1:0];
            ls_func3 == 3'b100:
                reject = ls_we;
            ls_func3 == 3'b101:
                reject = ls_we | ls_addr[0];
            default:
                reject = 1'b1;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;

    assign tmo_hit = (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (state == IDLE)
            cnt <= '0;
        else if (state == REQ || state == WAIT_R)
            cnt <= cnt + 1'b1;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d = state;
        tmo     = 1'b0;
        unique case (state)
            IDLE: begin
                if (ls_valid)
                    state_d = reject ? DONE : REQ;
            end
            REQ: begin
                if (bus.gnt)
                    state_d = we_q ? DONE : WAIT_R;
                else if (tmo_hit) begin
                    state_d = DONE;
                    tmo     = 1'b1;
                end
            end
            WAIT_R: begin
                if (bus.rvalid)
                    state_d = DONE;
                else if (tmo_hit) begin
                    state_d = DONE;
                    tmo     = 1'b1;
                end
            end
            DONE:
                state_d = IDLE;
            default:
                state_d = IDLE;
        endcase
    end

    always_comb begin
        strb = 4'b1111;
        unique case (1'b1)
            f3_q[1:0] == 2'b00: strb = 4'b0001 << addr_q[1:0];
            f3_q[1:0] == 2'b01: strb = 4'b0011 << addr_q[1:0];
            default:            strb = 4'b1111;
        endcase
    end

    // Bring the addressed byte/half down to bit 0 before extension
    assign sh = bus.rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        ext = sh;
        unique case (1'b1)
            f3_q == 3'b000: ext = {{24{sh[7]}}, sh[7:0]};
            f3_q == 3'b001: ext = {{16{sh[15]}}, sh[15:0]};
            f3_q == 3'b100: ext = {24'h0, sh[7:0]};
            f3_q == 3'b101: ext = {16'h0, sh[15:0]};
            default:        ext = sh;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state <= state_d;
            if (state == IDLE && ls_valid) begin
                we_q    <= ls_we;
                f3_q    <= ls_func3;
                addr_q  <= ls_addr;
                wdata_q <= ls_wdata;
                err_q   <= reject;
            end
            if (tmo)
                err_q <= 1'b1;
            if (state == WAIT_R && bus.rvalid)
                rdata_q <= ext;
        end
    end

    assign ls_busy   = (state != IDLE);
    assign ls_done   = (state == DONE);
    assign ls_err    = (state == DONE) & err_q;
    assign ls_rdata  = rdata_q;

    assign bus.req   = (state == REQ);
    assign bus.we    = we_q;
    assign bus.addr  = {addr_q[31:2], 2'b00};
    assign bus.wstrb = we_q ? strb : 4'b0000;
    assign bus.wdata = wdata_q << {addr_q[1:0], 3'b000};

endmodule

// File: tb/tb_lsu_bus_master.sv
// Directed bench for lsu_bus_master: stores, loads, rejects, back-to-back,
// timeout (LSU_TIMEOUT_EN) or indefinite wait, and reset mid-transfer.
module tb_lsu_bus_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        ls_valid;
    logic        ls_we;
    logic [2:0]  ls_func3;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_busy;
    logic        ls_done;
    logic        ls_err;
    logic [31:0] ls_rdata;

    int checks = 0;
    int errors = 0;

    lsu_bus_master_if bus();

    always #5 clk = ~clk;

`ifdef LSU_TIMEOUT_EN
    lsu_bus_master #(.TIMEOUT_CYCLES(4)) dut (
`else
    lsu_bus_master dut (
`endif
        .clk      (clk),
        .reset    (reset),
        .ls_valid (ls_valid),
        .ls_we    (ls_we),
        .ls_func3 (ls_func3),
        .ls_addr  (ls_addr),
        .ls_wdata (ls_wdata),
        .ls_busy  (ls_busy),
        .ls_done  (ls_done),
        .ls_err   (ls_err),
        .ls_rdata (ls_rdata),
        .bus      (bus.master)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        ls_valid = 1'b1;
        ls_we    = we;
        ls_func3 = f3;
        ls_addr  = a;
        ls_wdata = wd;
        step();
        ls_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        ls_valid   = 1'b1;
        bus.rvalid = 1'b1;
        bus.rdata  = 32'hFFFF_FFFF;
        step();
        step();
        checks++;
        if ({ls_busy, ls_done, ls_err, bus.req, bus.we} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctl: got %b want 00000",
                     {ls_busy, ls_done, ls_err, bus.req, bus.we});
        end
        checks++;
        if ({ls_rdata, bus.addr, bus.wdata, bus.wstrb} !== 100'b0) begin
            errors++;
            $display("FAIL reset_data: rdata=%h addr=%h wdata=%h strb=%b want all 0",
                     ls_rdata, bus.addr, bus.wdata, bus.wstrb);
        end
        ls_valid = 1'b0;
        reset    = 1'b0;
        step();
        checks++;
        if ({ls_busy, ls_done} !== 2'b00 || ls_rdata !== 32'h0) begin
            errors++;
            $display("FAIL stale_rvalid: busy=%b done=%b rdata=%h want 0 0 0",
                     ls_busy, ls_done, ls_rdata);
        end
        bus.rvalid = 1'b0;
        step();
    endtask

    task automatic test_store_word();
        issue(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
        checks++;
        if (bus.req !== 1'b1 || bus.we !== 1'b1 || bus.addr !== 32'h10 ||
            bus.wstrb !== 4'b1111 || bus.wdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL sw_bus: req=%b we=%b addr=%h strb=%b wdata=%h want 1 1 10 1111 deadbeef",
                     bus.req, bus.we, bus.addr, bus.wstrb, bus.wdata);
        end
        bus.gnt = 1'b1;
        step();
        bus.gnt = 1'b0;
        checks++;
        if (ls_done !== 1'b1 || ls_err !== 1'b0 || bus.req !== 1'b0) begin
            errors++;
            $display("FAIL sw_done: done=%b err=%b req=%b want 1 0 0",
                     ls_done, ls_err, bus.req);
        end
        step();
        checks++;
        if (ls_done !== 1'b0 || ls_busy !== 1'b0) begin
            errors++;
            $display("FAIL sw_idle: done=%b busy=%b want 0 0", ls_done, ls_busy);
        end
    endtask

    task automatic test_store_byte();
        issue(1'b1, 3'b000, 32'h13, 32'h0000_00A5);
        checks++;
        if (bus.req !== 1'b1 || bus.addr !== 32'h10 ||
            bus.wstrb !== 4'b1000 || bus.wdata !== 32'hA500_0000) begin
            errors++;
            $display("FAIL sb_bus: req=%b addr=%h strb=%b wdata=%h want 1 10 1000 a5000000",
                     bus.req, bus.addr, bus.wstrb, bus.wdata);
        end
        bus.gnt = 1'b1;
        step();
        bus.gnt = 1'b0;
        checks++;
        if (ls_done !== 1'b1 || ls_err !== 1'b0) begin
            errors++;
            $display("FAIL sb_done: done=%b err=%b want 1 0", ls_done, ls_err);
        end
        step();
    endtask

    task automatic test_loads();
        logic [2:0]  f3 [7] = '{3'b000, 3'b000, 3'b100, 3'b101,
                                3'b001, 3'b001, 3'b010};
        logic [31:0] ad [7] = '{32'h12, 32'h11, 32'h12, 32'h12,
                                32'h12, 32'h10, 32'h14};
        logic [31:0] rd [7] = '{32'h1280_FF00, 32'h1280_FF00, 32'h1280_FF00,
                                32'h1280_FF00, 32'h1280_FF00, 32'h1280_FF00,
                                32'hCAFE_F00D};
        logic [31:0] ex [7] = '{32'hFFFF_FF80, 32'hFFFF_FFFF, 32'h0000_0080,
                                32'h0000_1280, 32'h0000_1280, 32'hFFFF_FF00,
                                32'hCAFE_F00D};
        for (int i = 0; i < 7; i++) begin
            issue(1'b0, f3[i], ad[i], 32'h0);
            checks++;
            if (bus.req !== 1'b1 || bus.we !== 1'b0 || bus.wstrb !== 4'b0000 ||
                bus.addr !== {ad[i][31:2], 2'b00}) begin
                errors++;
                $display("FAIL ld%0d_bus: req=%b we=%b strb=%b addr=%h", i,
                         bus.req, bus.we, bus.wstrb, bus.addr);
            end
            bus.gnt = 1'b1;
            step();
            bus.gnt = 1'b0;
            checks++;
            if (ls_done !== 1'b0 || bus.req !== 1'b0) begin
                errors++;
                $display("FAIL ld%0d_wait: done=%b req=%b want 0 0", i, ls_done, bus.req);
            end
            bus.rvalid = 1'b1;
            bus.rdata  = rd[i];
            step();
            bus.rvalid = 1'b0;
            checks++;
            if (ls_done !== 1'b1 || ls_err !== 1'b0 || ls_rdata !== ex[i]) begin
                errors++;
                $display("FAIL ld%0d_data: done=%b err=%b rdata=%h want 1 0 %h", i,
                         ls_done, ls_err, ls_rdata, ex[i]);
            end
            step();
        end
    endtask

    task automatic test_reject();
        logic        we [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [2:0]  f3 [6] = '{3'b001, 3'b010, 3'b010, 3'b100, 3'b011, 3'b110};
        logic [31:0] ad [6] = '{32'h11, 32'h12, 32'h16, 32'h10, 32'h10, 32'h10};
        for (int i = 0; i < 6; i++) begin
            issue(we[i], f3[i], ad[i], 32'h1234_5678);
            checks++;
            if (ls_done !== 1'b1 || ls_err !== 1'b1 || bus.req !== 1'b0) begin
                errors++;
                $display("FAIL rej%0d: done=%b err=%b req=%b want 1 1 0", i,
                         ls_done, ls_err, bus.req);
            end
            step();
            checks++;
            if (ls_busy !== 1'b0 || bus.req !== 1'b0 || ls_rdata !== 32'hCAFE_F00D) begin
                errors++;
                $display("FAIL rej%0d_after: busy=%b req=%b rdata=%h want 0 0 cafef00d", i,
                         ls_busy, bus.req, ls_rdata);
            end
        end
    endtask

    task automatic test_back_to_back();
        issue(1'b1, 3'b010, 32'h40, 32'h1111_1111);
        bus.gnt = 1'b1;
        step();
        bus.gnt = 1'b0;
        ls_valid = 1'b1;
        ls_we    = 1'b1;
        ls_func3 = 3'b001;
        ls_addr  = 32'h22;
        ls_wdata = 32'h0000_1234;
        checks++;
        if (ls_done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first_done: done=%b want 1", ls_done);
        end
        step();
        checks++;
        if (ls_busy !== 1'b0 || ls_done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: busy=%b done=%b want 0 0", ls_busy, ls_done);
        end
        step();
        ls_valid = 1'b0;
        checks++;
        if (bus.req !== 1'b1 || bus.addr !== 32'h20 ||
            bus.wstrb !== 4'b1100 || bus.wdata !== 32'h1234_0000) begin
            errors++;
            $display("FAIL b2b_sh_bus: req=%b addr=%h strb=%b wdata=%h want 1 20 1100 12340000",
                     bus.req, bus.addr, bus.wstrb, bus.wdata);
        end
        bus.gnt = 1'b1;
        step();
        bus.gnt = 1'b0;
        checks++;
        if (ls_done !== 1'b1 || ls_err !== 1'b0 || ls_rdata !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL b2b_done: done=%b err=%b rdata=%h want 1 0 cafef00d",
                     ls_done, ls_err, ls_rdata);
        end
        step();
    endtask

    task automatic test_timeout();
        int n;
        n = 0;
        issue(1'b0, 3'b010, 32'h30, 32'h0);
`ifdef LSU_TIMEOUT_EN
        while (bus.req === 1'b1 && n < 20) begin
            n++;
            step();
        end
        checks++;
        if (n != 4 || ls_done !== 1'b1 || ls_err !== 1'b1 ||
            ls_rdata !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL timeout: req_cycles=%0d done=%b err=%b rdata=%h want 4 1 1 cafef00d",
                     n, ls_done, ls_err, ls_rdata);
        end
        step();
        checks++;
        if (ls_busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle: busy=%b want 0", ls_busy);
        end
`else
        while (bus.req === 1'b1 && n < 20) begin
            n++;
            step();
        end
        checks++;
        if (n != 20 || ls_busy !== 1'b1 || ls_done !== 1'b0) begin
            errors++;
            $display("FAIL no_timeout: req_cycles=%0d busy=%b done=%b want 20 1 0",
                     n, ls_busy, ls_done);
        end
        bus.gnt = 1'b1;
        step();
        bus.gnt    = 1'b0;
        bus.rvalid = 1'b1;
        bus.rdata  = 32'h0102_0304;
        step();
        bus.rvalid = 1'b0;
        checks++;
        if (ls_done !== 1'b1 || ls_err !== 1'b0 || ls_rdata !== 32'h0102_0304) begin
            errors++;
            $display("FAIL late_gnt: done=%b err=%b rdata=%h want 1 0 01020304",
                     ls_done, ls_err, ls_rdata);
        end
        step();
`endif
    endtask

    task automatic test_reset_mid();
        logic seen_done;
        seen_done = 1'b0;
        issue(1'b0, 3'b010, 32'h20, 32'h0);
        bus.gnt = 1'b1;
        step();
        bus.gnt = 1'b0;
        checks++;
        if (ls_busy !== 1'b1 || bus.req !== 1'b0) begin
            errors++;
            $display("FAIL mid_wait: busy=%b req=%b want 1 0", ls_busy, bus.req);
        end
        reset = 1'b1;
        step();
        reset      = 1'b0;
        bus.rvalid = 1'b1;
        bus.rdata  = 32'h5555_5555;
        seen_done  = seen_done | ls_done;
        step();
        bus.rvalid = 1'b0;
        seen_done  = seen_done | ls_done;
        step();
        seen_done  = seen_done | ls_done;
        checks++;
        if (seen_done !== 1'b0 || ls_busy !== 1'b0 || ls_rdata !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset: done_seen=%b busy=%b rdata=%h want 0 0 0",
                     seen_done, ls_busy, ls_rdata);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        ls_valid   = 1'b0;
        ls_we      = 1'b0;
        ls_func3   = 3'b000;
        ls_addr    = 32'h0;
        ls_wdata   = 32'h0;
        bus.gnt    = 1'b0;
        bus.rvalid = 1'b0;
        bus.rdata  = 32'h0;
        test_reset();
        test_store_word();
        test_store_byte();
        test_loads();
        test_reject();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
